// File: rtl/seq_div2c.sv
// Sequential radix-2 restoring divider: recovers the signed multiplicand X and
// remainder R from a signed product Z and an unsigned multiplier Y.
module seq_div2c #(
  parameter int ZW = 12,
  parameter int YW = 4,
  parameter int XW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [ZW-1:0] Z,
  input  logic [YW-1:0] Y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [ZW-1:0] Q,
  output logic [XW-1:0] X,
  output logic [YW:0]   R,
  output logic          ovf,
  output logic          dbz
);

  localparam int CW = $clog2(ZW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [ZW-1:0] dvd_q, dvd_d;
  logic [YW-1:0] div_q, div_d;
  logic          neg_q, neg_d;
  logic [YW:0]   rem_q, rem_d;
  logic [ZW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ZW-1:0] q_out_q, q_out_d;
  logic [YW:0]   r_out_q, r_out_d;
  logic          ovf_q, ovf_d;
  logic          dbz_q, dbz_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [ZW-1:0] z_abs_s;
  logic [YW:0]   rem_sh_s;
  logic [YW:0]   rem_sub_s;
  logic          ge_s;
  logic [ZW-1:0] q_fix_s;
  logic [YW:0]   r_fix_s;
  logic          ovf_fix_s;

  // |Z| as unsigned: -2048 maps to 0x800, which is exactly 2048.
  assign z_abs_s   = Z[ZW-1] ? (~Z + {{(ZW-1){1'b0}}, 1'b1}) : Z;
  assign rem_sh_s  = {rem_q[YW-1:0], dvd_q[ZW-1]};
  assign ge_s      = (rem_sh_s >= {1'b0, div_q});
  assign rem_sub_s = rem_sh_s - {1'b0, div_q};
  assign q_fix_s   = neg_q ? (~quo_q + {{(ZW-1){1'b0}}, 1'b1}) : quo_q;
  assign r_fix_s   = neg_q ? (~rem_q + {{YW{1'b0}}, 1'b1}) : rem_q;
  // Fits the signed XW range only if the bits above XW-1 all copy the sign bit.
  assign ovf_fix_s = !((&q_fix_s[ZW-1:XW-1]) || !(|q_fix_s[ZW-1:XW-1]));

  // Next-state and datapath update for the divider sequence.
  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    div_d    = div_q;
    neg_d    = neg_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    q_out_d  = q_out_q;
    r_out_d  = r_out_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dvd_d   = z_abs_s;
          div_d   = Y;
          neg_d   = Z[ZW-1];
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CW'(ZW - 1);
          state_d = (Y == {YW{1'b0}}) ? S_FIX : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        rem_d = ge_s ? rem_sub_s : rem_sh_s;
        quo_d = {quo_q[ZW-2:0], ge_s};
        dvd_d = {dvd_q[ZW-2:0], 1'b0};
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_FIX: begin
        // Divide-by-zero arrives here with quotient and remainder already cleared.
        q_out_d = q_fix_s;
        r_out_d = r_fix_s;
        ovf_d   = ovf_fix_s;
        dbz_d   = (div_q == {YW{1'b0}});
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      div_q       <= '0;
      neg_q       <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      q_out_q     <= '0;
      r_out_q     <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      div_q       <= div_d;
      neg_q       <= neg_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      q_out_q     <= q_out_d;
      r_out_q     <= r_out_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Q         = q_out_q;
  assign X         = q_out_q[XW-1:0];
  assign R         = r_out_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_div2c.sv
// Self-checking bench for seq_div2c: directed test-plan cases plus random
// operands compared against a plain-arithmetic truncating-division model.
module tb_seq_div2c;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] Z;
  logic [3:0]  Y;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] Q;
  logic [7:0]  X;
  logic [4:0]  R;
  logic        ovf;
  logic        dbz;

  int checks = 0;
  int errors = 0;

  seq_div2c #(.ZW(12), .YW(4), .XW(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Z(Z), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .X(X), .R(R), .ovf(ovf), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [11:0] z, input logic [3:0] y, input int hold);
    int   zs, q, r, cyc;
    logic [11:0] eq;
    logic [4:0]  er;
    logic eovf, edbz, got;
    zs = int'($signed(z));
    if (y == 4'd0) begin
      q = 0; r = 0; edbz = 1'b1;
    end else begin
      q = zs / int'(y);
      r = zs - q * int'(y);
      edbz = 1'b0;
    end
    eovf = (q > 127) || (q < -128);
    eq = q[11:0];
    er = r[4:0];

    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; Z = z; Y = y;
    @(posedge clk);
    @(negedge clk);
    // Junk on the inputs while busy must not be captured.
    in_valid = 1'($urandom_range(0, 1));
    Z = 12'($urandom_range(0, 4095));
    Y = 4'($urandom_range(0, 15));
    cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); cyc++;
      @(negedge clk); got = out_valid;
    end
    chk("done_seen", 32'(got), 32'd1);
    if (got) begin
      chk("latency", 32'(cyc), (y == 4'd0) ? 32'd1 : 32'd13);
      chk("Q", 32'(Q), 32'(eq));
      chk("X", 32'(X), 32'(eq[7:0]));
      chk("R", 32'(R), 32'(er));
      chk("ovf", 32'(ovf), 32'(eovf));
      chk("dbz", 32'(dbz), 32'(edbz));
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); @(negedge clk);
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        chk("hold_Q", 32'(Q), 32'(eq));
        chk("hold_R", 32'(R), 32'(er));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_Q_held", 32'(Q), 32'(eq));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; Z = 12'd0; Y = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_Q", 32'(Q), 32'd0);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_flags", 32'({ovf, dbz}), 32'd0);
    reset = 1'b0;

    do_op(12'h064, 4'd7, 0);
    chk("tp_100_7_Q", 32'(Q), 32'h00E);
    do_op(12'hF9C, 4'd7, 0);
    chk("tp_m100_7_R", 32'(R), 32'h1E);
    do_op(12'hC17, 4'd13, 0);
    chk("tp_roundtrip_X", 32'(X), 32'hB3);
    do_op(12'h800, 4'd1, 0);
    chk("tp_min_ovf", 32'(ovf), 32'd1);
    do_op(12'h123, 4'd0, 0);
    chk("tp_dbz", 32'(dbz), 32'd1);
    do_op(12'h064, 4'd7, 5);
    do_op(12'h7FF, 4'd15, 1);
    do_op(12'h801, 4'd2, 0);

    for (int n = 0; n < 30; n++) begin
      do_op(12'($urandom_range(0, 4095)), 4'($urandom_range(0, 15)),
            int'($urandom_range(0, 2)));
    end

    // Leave nonzero outputs, then reset in the sixth CALC cycle.
    do_op(12'hF9C, 4'd7, 0);
    @(negedge clk);
    in_valid = 1'b1; Z = 12'h064; Y = 4'd7;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_Q", 32'(Q), 32'd0);
    chk("mid_rst_X", 32'(X), 32'd0);
    chk("mid_rst_R", 32'(R), 32'd0);
    chk("mid_rst_flags", 32'({ovf, dbz}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(12'h064, 4'd7, 0);
    chk("after_rst_Q", 32'(Q), 32'h00E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
